// File: rtl/fg_cfg_writer.sv
// fg_cfg_writer: host-side initiator for the function generator's parallel
// configuration port. Captures a full configuration word on start_i and
// writes it into CR0..CR(NUM_REGS-1) over data/addr/wr_n/en_n. The phases
// are stretched so that a receiver behind SYNC_STAGES synchronizer flops
// sees a clean disable, stable address/data, and a complete write pulse.
//
// Optional build macro: FG_CFG_WRITER_MASK_EN adds wr_mask_i, a per-register
// write mask captured with the word. Masked-off registers are skipped.
//
// Request handshake: start_i is a single-cycle request, accepted only while
// idle (busy_o=0, done_o=0 and the FSM in IDLE); requests at any other time
// are dropped, never queued. Completion is signalled by a one-cycle done_o.
module fg_cfg_writer #(
    parameter int NUM_REGS     = 7,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  run_i,
    input  logic [8*NUM_REGS-1:0] cfg_data_i,
`ifdef FG_CFG_WRITER_MASK_EN
    input  logic [NUM_REGS-1:0]   wr_mask_i,
`endif
    output logic [7:0]            data_o,
    output logic [2:0]            addr_o,
    output logic                  wr_n_o,
    output logic                  en_n_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Disable-wait and post-pulse hold both cover the receiver's sync delay.
    localparam int HOLD_LEN  = SYNC_STAGES + 1;
    localparam int CNT_MAX_A = (HOLD_LEN > SETUP_CYCLES) ? HOLD_LEN : SETUP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > PULSE_CYCLES) ? CNT_MAX_A : PULSE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DISABLE = 3'd1,
        S_SETUP   = 3'd2,
        S_PULSE   = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [2:0]            idx, idx_nx;
    logic [8*NUM_REGS-1:0] shadow, shadow_nx;
    logic [NUM_REGS-1:0]   mask, mask_nx;
    logic [NUM_REGS-1:0]   mask_in;
    logic [3:0]            nxt;

    logic [7:0]            data_nx;
    logic [2:0]            addr_nx;
    logic                  wr_n_nx;
    logic                  en_n_nx;
    logic                  busy_nx;
    logic                  done_nx;

`ifdef FG_CFG_WRITER_MASK_EN
    assign mask_in = wr_mask_i;
`else
    assign mask_in = '1;
`endif

    // Lowest register index >= from whose mask bit is set; bit 3 = found.
    function automatic logic [3:0] next_reg(input logic [NUM_REGS-1:0] m,
                                            input int from);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            if (k >= from && m[k]) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    // Next-state, counter and shadow update; outputs decoded from the next state.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        shadow_nx = shadow;
        mask_nx   = mask;
        nxt       = 4'b0000;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    shadow_nx = cfg_data_i;
                    mask_nx   = mask_in;
                    state_nx  = S_DISABLE;
                    cnt_nx    = CNT_W'(HOLD_LEN - 1);
                end
            end
            S_DISABLE: begin
                if (cnt == '0) begin
                    nxt = next_reg(mask, 0);
                    if (nxt[3]) begin
                        state_nx = S_SETUP;
                        idx_nx   = nxt[2:0];
                        cnt_nx   = CNT_W'(SETUP_CYCLES - 1);
                    end else begin
                        state_nx = S_DONE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_PULSE;
                    cnt_nx   = CNT_W'(PULSE_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nx = S_HOLD;
                    cnt_nx   = CNT_W'(HOLD_LEN - 1);
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    nxt = next_reg(mask, int'(idx) + 1);
                    if (nxt[3]) begin
                        state_nx = S_SETUP;
                        idx_nx   = nxt[2:0];
                        cnt_nx   = CNT_W'(SETUP_CYCLES - 1);
                    end else begin
                        state_nx = S_DONE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        data_nx = 8'h00;
        addr_nx = 3'd0;
        wr_n_nx = 1'b1;
        busy_nx = 1'b0;
        done_nx = 1'b0;
        // The FG follows run_i only while idle; leaving DONE keeps it disabled one more cycle.
        en_n_nx = (state == S_IDLE && state_nx == S_IDLE) ? !run_i : 1'b1;

        case (state_nx)
            S_DISABLE: begin
                busy_nx = 1'b1;
            end
            S_SETUP, S_PULSE, S_HOLD: begin
                busy_nx = 1'b1;
                addr_nx = idx_nx;
                data_nx = shadow_nx[8*(NUM_REGS-1-int'(idx_nx)) +: 8];
                wr_n_nx = (state_nx != S_PULSE);
            end
            S_DONE: begin
                done_nx = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counters, shadow word and registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= 3'd0;
            shadow <= '0;
            mask   <= '0;
            data_o <= 8'h00;
            addr_o <= 3'd0;
            wr_n_o <= 1'b1;
            en_n_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            shadow <= shadow_nx;
            mask   <= mask_nx;
            data_o <= data_nx;
            addr_o <= addr_nx;
            wr_n_o <= wr_n_nx;
            en_n_o <= en_n_nx;
            busy_o <= busy_nx;
            done_o <= done_nx;
        end
    end

endmodule

// File: tb/tb_fg_cfg_writer.sv
// tb_fg_cfg_writer: directed bench for fg_cfg_writer with a 2-stage receiver
// synchronizer model, an expected-write queue and per-pulse timing monitor.
// Build with +define+FG_CFG_WRITER_MASK_EN to include the mask steps.
module tb_fg_cfg_writer;

    localparam int NUM_REGS  = 7;
    localparam int PULSE_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        run_i;
    logic [55:0] cfg_data_i;
`ifdef FG_CFG_WRITER_MASK_EN
    logic [6:0]  wr_mask_i;
`endif
    logic [7:0]  data_o;
    logic [2:0]  addr_o;
    logic        wr_n_o;
    logic        en_n_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    fg_cfg_writer #(
        .NUM_REGS    (7),
        .SYNC_STAGES (2),
        .SETUP_CYCLES(1),
        .PULSE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .run_i     (run_i),
        .cfg_data_i(cfg_data_i),
`ifdef FG_CFG_WRITER_MASK_EN
        .wr_mask_i (wr_mask_i),
`endif
        .data_o    (data_o),
        .addr_o    (addr_o),
        .wr_n_o    (wr_n_o),
        .en_n_o    (en_n_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    // Receiver: {wr_n, en_n, addr, data} through two flops, write while wr_n low.
    logic [12:0] rx_s1 = 13'h1FFF;
    logic [12:0] rx_s2 = 13'h1FFF;
    logic [7:0]  rx_reg [8] = '{default: 8'hEE};

    always @(posedge clk) begin
        rx_s1 <= {wr_n_o, en_n_o, addr_o, data_o};
        rx_s2 <= rx_s1;
        if (!rx_s2[12]) rx_reg[rx_s2[10:8]] <= rx_s2[7:0];
    end

    // Scoreboard and monitor state.
    logic [10:0] exp_q[$];
    logic [7:0]  exp_rx [8] = '{default: 8'hEE};
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_wr_n = 1'b1;
    logic        prev_busy = 1'b0;
    logic [10:0] prev_ad = '0;
    logic [10:0] held_ad = '0;
    logic [10:0] cur_ad;
    logic [10:0] exp_ad;
    int          pulse_len = 0;
    int          hold_left = 0;
    int          en_hi = 0;
    int          busy_len = 0;
    int          last_busy_len = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and run the pin-level monitor on the falling edge.
    task step();
        @(negedge clk);
        cur_ad = {addr_o, data_o};
        if (busy_o) check("en_during_seq", en_n_o, 1'b1);
        if (prev_wr_n && !wr_n_o) begin
            check("setup_stable", cur_ad, prev_ad);
            check("en_before_wr", en_hi >= 3, 1'b1);
            check("write_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_ad = exp_q.pop_front();
                check("write_addr_data", cur_ad, exp_ad);
            end
            pulse_len = 1;
        end else if (!prev_wr_n && !wr_n_o) begin
            pulse_len++;
            check("pulse_stable", cur_ad, prev_ad);
        end else if (!prev_wr_n && wr_n_o && busy_o) begin
            check("pulse_len", pulse_len, PULSE_LEN);
            check("hold_stable", cur_ad, prev_ad);
            held_ad   = prev_ad;
            hold_left = 2;
        end else if (hold_left > 0) begin
            if (busy_o) check("hold_stable", cur_ad, held_ad);
            hold_left--;
        end
        en_hi = en_n_o ? en_hi + 1 : 0;
        if (busy_o) busy_len++;
        else if (prev_busy) begin
            last_busy_len = busy_len;
            busy_len      = 0;
        end
        prev_busy = busy_o;
        prev_wr_n = wr_n_o;
        prev_ad   = cur_ad;
    endtask

    task automatic push_word(input logic [55:0] w, input logic [6:0] m);
        for (int k = 0; k < NUM_REGS; k++) begin
            if (m[k]) exp_q.push_back({3'(k), w[8*(6-k) +: 8]});
        end
    endtask

    task automatic set_rx(input logic [55:0] w, input logic [6:0] m);
        for (int k = 0; k < NUM_REGS; k++) begin
            if (m[k]) exp_rx[k] = w[8*(6-k) +: 8];
        end
    endtask

    task automatic check_rx(input string tag, input logic [6:0] which);
        for (int k = 0; k < NUM_REGS; k++) begin
            if (which[k]) check(tag, rx_reg[k], exp_rx[k]);
        end
    endtask

    task start_seq(input logic [55:0] w);
        cfg_data_i = w;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    task wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && !done_o; i++) step();
        check("done_seen", done_o, 1'b1);
    endtask

    // Hard stop in case something deadlocks outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [55:0] w1, w2, w3;
        w1 = 56'h61_40_68_00_00_00_32;
        w2 = 56'({$urandom(), $urandom()});
        w3 = 56'hA1_B2_C3_D4_E5_F6_07;

        // Reset with FG requested to run.
        rst_n      = 1'b0;
        start_i    = 1'b0;
        run_i      = 1'b1;
        cfg_data_i = '0;
`ifdef FG_CFG_WRITER_MASK_EN
        wr_mask_i  = 7'h7F;
`endif
        repeat (3) step();
        check("rst_en_n", en_n_o, 1'b1);
        check("rst_wr_n", wr_n_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_addr_data", {addr_o, data_o}, 11'h000);
        rst_n = 1'b1;
        step();
        check("idle_en_follows_run", en_n_o, 1'b0);
        check("idle_wr_n", wr_n_o, 1'b1);
        check("idle_data", data_o, 8'h00);

        // Full write; a second start and new data mid-sequence must be ignored.
        push_word(w1, 7'h7F);
        set_rx(w1, 7'h7F);
        start_seq(w1);
        repeat (20) step();
        cfg_data_i = 56'hFF_FF_FF_FF_FF_FF_FF;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        wait_done(100);
        check("busy_len_full", last_busy_len, 59);
        check("queue_drained_1", exp_q.size(), 0);
        step();
        check("done_one_cycle", done_o, 1'b0);
        check("en_after_done", en_n_o, 1'b1);
        step();
        check("en_follows_run_after_done", en_n_o, 1'b0);
        repeat (5) step();
        check("no_queued_restart", busy_o, 1'b0);
        check_rx("rx_word1", 7'h7F);

        // Random word with FG not running.
        run_i = 1'b0;
        step();
        check("idle_en_run0", en_n_o, 1'b1);
        push_word(w2, 7'h7F);
        set_rx(w2, 7'h7F);
        start_seq(w2);
        wait_done(100);
        check("busy_len_rand", last_busy_len, 59);
        check("queue_drained_2", exp_q.size(), 0);
        repeat (5) step();
        check_rx("rx_word2", 7'h7F);

        // Reset during the write pulse of register 3.
        run_i = 1'b1;
        push_word(w3, 7'h7F);
        set_rx(w3, 7'b0000111);
        start_seq(w3);
        for (int i = 0; i < 200 && !(addr_o == 3'd3 && !wr_n_o); i++) step();
        check("reached_reg3_pulse", {addr_o, wr_n_o}, {3'd3, 1'b0});
        rst_n = 1'b0;
        step();
        check("abort_wr_n", wr_n_o, 1'b1);
        check("abort_en_n", en_n_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        check("abort_pending_writes", exp_q.size(), 3);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (5) step();
        check_rx("rx_after_abort", 7'b1110111);

        // start_i in the same cycle as reset: reset wins, nothing starts.
        rst_n = 1'b0;
        start_seq(w1);
        check("rst_start_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        repeat (4) step();
        check("rst_start_no_seq", busy_o, 1'b0);

`ifdef FG_CFG_WRITER_MASK_EN
        // Only registers 0 and 2.
        wr_mask_i = 7'b0000101;
        push_word(w2 ^ 56'h11_22_33_44_55_66_77, wr_mask_i);
        set_rx(w2 ^ 56'h11_22_33_44_55_66_77, wr_mask_i);
        start_seq(w2 ^ 56'h11_22_33_44_55_66_77);
        wr_mask_i = 7'h7F;
        wait_done(100);
        check("busy_len_mask", last_busy_len, 19);
        check("queue_drained_mask", exp_q.size(), 0);
        repeat (5) step();
        check_rx("rx_mask", 7'h7F);

        // Empty mask: disable wait then done.
        wr_mask_i = 7'b0000000;
        start_seq(w1);
        wait_done(20);
        check("busy_len_mask0", last_busy_len, 3);
        wr_mask_i = 7'h7F;
        repeat (3) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fg_cfg_writer.md
Name: fg_cfg_writer

Overview:
Host-side initiator for the function generator's parallel configuration port. It loads a full 56-bit configuration word and writes it into CR0..CR6 over the 8-bit data, 3-bit address, write-enable and enable pins. Its timing is sized for the receiver's 2-stage input synchronizers. It sits in the host/test FPGA fabric, or in a companion block, and drives the FG's ui_in and uio_in[7:3] directly.

Parameters:
NUM_REGS, 7, number of config registers written (address 0..NUM_REGS-1)
SYNC_STAGES, 2, receiver synchronizer depth; sets the disable-wait and hold length to SYNC_STAGES+1 cycles
SETUP_CYCLES, 1, cycles addr/data are stable before wr_n_o falls (>=1)
PULSE_CYCLES, 4, cycles wr_n_o is held low (>=SYNC_STAGES+1)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start_i  input  1  one-cycle request to write the whole configuration; honoured only in IDLE
run_i  input  1  desired FG run state while IDLE (1 = FG enabled)
cfg_data_i  input  8*NUM_REGS  config word; CR0 = bits [55:48] ... CR6 = bits [7:0]
data_o  output  8  to FG ui_in
addr_o  output  3  to FG uio_in[5:3]
wr_n_o  output  1  to FG uio_in[6], active-low write enable
en_n_o  output  1  to FG uio_in[7], active-low FG enable
busy_o  output  1  write sequence in progress
done_o  output  1  one-cycle pulse when the sequence completes

Behaviour:
- All outputs are registered. Reset values: data_o=0, addr_o=0, wr_n_o=1, en_n_o=1, busy_o=0, done_o=0, state=IDLE. Reset mid-sequence aborts immediately; a partially written register is not retried.
- IDLE: en_n_o <= !run_i; wr_n_o=1; data_o/addr_o=0. If start_i=1, capture cfg_data_i (and the mask, if compiled in) into a shadow register, then go to DISABLE. Changes to inputs during the sequence are ignored.
- DISABLE: en_n_o=1, wr_n_o=1, busy_o=1, for SYNC_STAGES+1 cycles. This lets the receiver see enable deasserted before any write.
- Per register k, ascending from 0:
  - SETUP: addr_o=k, data_o=shadow[8*(NUM_REGS-1-k)+:8], wr_n_o=1, for SETUP_CYCLES cycles.
  - PULSE: wr_n_o=0 for PULSE_CYCLES cycles; addr/data held.
  - HOLD: wr_n_o=1 for SYNC_STAGES+1 cycles; addr/data still held, because the receiver sees wr low for SYNC_STAGES extra cycles.
- DONE: one cycle. busy_o=0, done_o=1, en_n_o=1, addr/data return to 0. Then IDLE, where en_n_o follows run_i from the next cycle.
- start_i during DISABLE/SETUP/PULSE/HOLD/DONE is ignored; no queuing.
- start_i and !rst_n in the same cycle: reset wins.
- Throughout the sequence, en_n_o stays 1 regardless of run_i.
- Default total: busy_o high for 3 + 7*(1+4+3) = 59 cycles, followed by a 1-cycle done_o.
- One shared down-counter sized for max(SYNC_STAGES+1, SETUP_CYCLES, PULSE_CYCLES). The register index counter wraps never; the last index is NUM_REGS-1.

Optional Feature:
FG_CFG_WRITER_MASK_EN
- Defined: adds input wr_mask_i [NUM_REGS-1:0], captured at start. Register k is written only if its mask bit is 1; unmasked registers are skipped entirely, with no SETUP/PULSE/HOLD cycles and no addr change.
- All-zero mask: DISABLE, then DONE (busy for SYNC_STAGES+1 cycles).
- Undefined: port absent; every register is written.

Test Plan:
- Reset, then idle with run_i=1 -> en_n_o=1 during reset; en_n_o=0 on the cycle after the first idle clock; wr_n_o=1; data_o=0.
- start_i with cfg_data_i=0x61_40_68_00_00_00_32, behind the 2-stage receiver synchronizer model -> 7 wr_n_o low pulses of 4 cycles at addr 0..6 with data 61,40,68,00,00,00,32. Receiver regs match. busy_o high 59 cycles, then done_o for 1 cycle.
- Per pulse -> addr/data stable from 1 cycle before wr_n_o falls until 3 cycles after it rises. en_n_o=1 at least 3 cycles before the first wr_n_o fall.
- Second start_i pulse, and cfg_data_i changes, mid-sequence -> no restart; written values come from the captured word.
- rst_n low during PULSE of register 3 -> next cycle wr_n_o=1, en_n_o=1, busy_o=0; registers 0..2 written, 4..6 untouched.
- FG_CFG_WRITER_MASK_EN with mask 7'b0000101 -> only addr 0 and 2 written; busy 3+2*8=19 cycles. Mask 0 -> busy 3 cycles, then done_o.
